// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the scratch-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_LEN_W  = 5;

    localparam int REQ_FILT = 0;
    localparam int REQ_IN   = 1;
    localparam int REQ_WB   = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin choice: first requester at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner
);

    logic [PTR_W-1:0] cand;

    // Scan from the farthest offset down so the closest requester to rr_ptr wins last.
    always_comb begin
        valid  = |req;
        winner = '0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[cand]) winner = cand;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single scratch memory port among burst masters: round-robin grant,
// address sequencing, write strobes and read data return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = MEM_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_base,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic                    beat,
    output logic [DATA_W-1:0]       rdata,
    output logic                    burst_done,
    output logic                    busy,
    output logic [ADDR_W-1:0]       mem_index,
    output logic [DATA_W-1:0]       mem_in,
    output logic                    mem_wr,
    input  logic [DATA_W-1:0]       mem_out
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state, state_n;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner_q;
    logic [PTR_W-1:0] pick_id;
    logic             pick_valid;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] last_q;
    logic [LEN_W-1:0] pick_len;
    logic [N_REQ-1:0] gnt_q;
    logic [ADDR_W-1:0] mem_index_q;
    logic             mem_wr_q;
    logic             last_beat;

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    assign pick_len  = req_len[int'(pick_id)*LEN_W +: LEN_W];
    assign last_beat = (beat_cnt == last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = XFER;
            XFER:    if (last_beat)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Burst registers; address, grant and strobe are registered so nothing on the
    // memory side depends combinationally on req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            winner_q    <= '0;
            beat_cnt    <= '0;
            last_q      <= '0;
            gnt_q       <= '0;
            mem_index_q <= '0;
            mem_wr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner_q    <= pick_id;
                        beat_cnt    <= '0;
                        last_q      <= (pick_len == '0) ? '0 : pick_len - 1'b1;
                        gnt_q       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
                        mem_index_q <= req_base[int'(pick_id)*ADDR_W +: ADDR_W];
                        mem_wr_q    <= req_wr[pick_id];
                    end
                end
                XFER: begin
                    beat_cnt    <= beat_cnt + 1'b1;
                    mem_index_q <= mem_index_q + 1'b1;
                    if (last_beat) begin
                        gnt_q       <= '0;
                        mem_wr_q    <= 1'b0;
                        mem_index_q <= '0;
                    end
                end
                DONE: begin
                    rr_ptr <= (int'(winner_q) == N_REQ - 1) ? '0 : winner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign beat       = (state == XFER);
    assign burst_done = (state == DONE);
    assign busy       = (state != IDLE);
    assign mem_index  = mem_index_q;
    assign mem_wr     = mem_wr_q;
    assign mem_in     = mem_wr_q ? req_wdata[int'(winner_q)*DATA_W +: DATA_W] : '0;
    assign rdata      = mem_out;

endmodule
